rx_tx_buffer_arbiter: RTL

Sequencer and arbiter for the endpoint's shared single-port 64-byte data buffer RAM. Four requesters share it: the USB RX packet decoder storing bytes, the USB TX encoder fetching bytes, and the AHB-Lite slave getting and storing bytes. It grants one RAM access per cycle and maintains the FIFO pointers and the `buffer_occupancy` count consumed by the AHB-Lite slave. It also executes the `clear` flush.

---
 rtl/rx_tx_buffer_arbiter_if.sv | 43 ++++
 rtl/rx_tx_buffer_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/rx_tx_buffer_arbiter_if.sv
// Bundle of requester handshakes, status outputs and RAM port for rx_tx_buffer_arbiter.
// master = requesters/RAM side, slave = the arbiter.
interface rx_tx_buffer_arbiter_if #(
  parameter int ADDR_W = 6
);
  logic              clear;
  logic              store_rx_packet_data;
  logic [7:0]        rx_packet_data;
  logic              get_tx_packet_data;
  logic              store_tx_data;
  logic [7:0]        tx_data;
  logic              get_rx_data;
  logic              rx_store_ack;
  logic              tx_get_ack;
  logic              ahb_store_ack;
  logic              ahb_get_ack;
  logic [7:0]        tx_packet_data;
  logic [7:0]        rx_data;
  logic [ADDR_W:0]   buffer_occupancy;
  logic              overflow;
  logic              underflow;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport master (
    output clear, store_rx_packet_data, rx_packet_data, get_tx_packet_data,
           store_tx_data, tx_data, get_rx_data, mem_rdata,
    input  rx_store_ack, tx_get_ack, ahb_store_ack, ahb_get_ack, tx_packet_data,
           rx_data, buffer_occupancy, overflow, underflow, mem_en, mem_we,
           mem_addr, mem_wdata
  );

  modport slave (
    input  clear, store_rx_packet_data, rx_packet_data, get_tx_packet_data,
           store_tx_data, tx_data, get_rx_data, mem_rdata,
    output rx_store_ack, tx_get_ack, ahb_store_ack, ahb_get_ack, tx_packet_data,
           rx_data, buffer_occupancy, overflow, underflow, mem_en, mem_we,
           mem_addr, mem_wdata
  );
endinterface

// File: rtl/rx_tx_buffer_arbiter.sv
// One-access-per-cycle arbiter and FIFO sequencer for the shared 64-byte endpoint buffer RAM.
// Optional: define BUF_ERR_EN to build the sticky overflow/underflow flags.
module rx_tx_buffer_arbiter #(
  parameter int DEPTH        = 64,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int STARVE_LIMIT = 4
) (
  input logic                   clk,
  input logic                   n_rst,
  rx_tx_buffer_arbiter_if.slave bus
);

  typedef enum logic [1:0] {TAG_NONE, TAG_TX, TAG_AHB} tag_t;
  typedef enum logic [2:0] {GNT_NONE, GNT_RX_STORE, GNT_TX_GET, GNT_AHB_STORE, GNT_AHB_GET} grant_t;

  localparam logic [2:0]      STARVE_LIM = 3'(STARVE_LIMIT);
  localparam logic [ADDR_W:0] PTR_ONE    = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] wptr, rptr, wptr_next, rptr_next;
  logic [2:0]      starve, starve_next;
  logic            ahb_turn;
  tag_t            tag, tag_next;
  logic [7:0]      tx_q, rx_q;
  grant_t          grant;
  logic            ahb_req, ahb_pick_store, ahb_ack;
  logic            full, empty, is_write, is_read, do_write, do_read;

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);

  // Once an AHB request has waited STARVE_LIMIT cycles it jumps ahead of the USB side.
  always_comb begin
    grant          = GNT_NONE;
    ahb_req        = bus.store_tx_data | bus.get_rx_data;
    ahb_pick_store = bus.store_tx_data & (~bus.get_rx_data | ahb_turn);
    if (n_rst && !bus.clear) begin
      if (ahb_req && (starve >= STARVE_LIM))
        grant = ahb_pick_store ? GNT_AHB_STORE : GNT_AHB_GET;
      else if (bus.store_rx_packet_data)
        grant = GNT_RX_STORE;
      else if (bus.get_tx_packet_data)
        grant = GNT_TX_GET;
      else if (ahb_req)
        grant = ahb_pick_store ? GNT_AHB_STORE : GNT_AHB_GET;
    end
  end

  always_comb begin
    is_write = (grant == GNT_RX_STORE) || (grant == GNT_AHB_STORE);
    is_read  = (grant == GNT_TX_GET)   || (grant == GNT_AHB_GET);
    ahb_ack  = (grant == GNT_AHB_STORE) || (grant == GNT_AHB_GET);
    do_write = is_write && !full;
    do_read  = is_read && !empty;

    bus.rx_store_ack  = (grant == GNT_RX_STORE);
    bus.tx_get_ack    = (grant == GNT_TX_GET);
    bus.ahb_store_ack = (grant == GNT_AHB_STORE);
    bus.ahb_get_ack   = (grant == GNT_AHB_GET);

    bus.mem_en    = do_write | do_read;
    bus.mem_we    = do_write;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (do_write) begin
      bus.mem_addr  = wptr[ADDR_W-1:0];
      bus.mem_wdata = (grant == GNT_RX_STORE) ? bus.rx_packet_data : bus.tx_data;
    end else if (do_read) begin
      bus.mem_addr = rptr[ADDR_W-1:0];
    end

    wptr_next = wptr;
    rptr_next = rptr;
    tag_next  = TAG_NONE;
    if (bus.clear) begin
      wptr_next = '0;
      rptr_next = '0;
    end else begin
      if (do_write) wptr_next = wptr + PTR_ONE;
      if (do_read) begin
        rptr_next = rptr + PTR_ONE;
        tag_next  = (grant == GNT_TX_GET) ? TAG_TX : TAG_AHB;
      end
    end

    starve_next = starve;
    if (bus.clear || !ahb_req || ahb_ack)
      starve_next = '0;
    else if (starve != 3'd7)
      starve_next = starve + 3'd1;
  end

  // The RAM answers one cycle after the read strobe, so the tag steers that late byte.
  // An empty read lands after any older capture so the requester sees 0x00.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr     <= '0;
      rptr     <= '0;
      starve   <= '0;
      ahb_turn <= 1'b0;
      tag      <= TAG_NONE;
      tx_q     <= 8'h00;
      rx_q     <= 8'h00;
    end else begin
      wptr   <= wptr_next;
      rptr   <= rptr_next;
      starve <= starve_next;
      tag    <= tag_next;
      if (ahb_ack) ahb_turn <= ~ahb_turn;
      case (tag)
        TAG_TX:  tx_q <= bus.mem_rdata;
        TAG_AHB: rx_q <= bus.mem_rdata;
        default: ;
      endcase
      if ((grant == GNT_TX_GET) && empty)  tx_q <= 8'h00;
      if ((grant == GNT_AHB_GET) && empty) rx_q <= 8'h00;
    end
  end

  assign bus.tx_packet_data   = tx_q;
  assign bus.rx_data          = rx_q;
  assign bus.buffer_occupancy = wptr - rptr;

`ifdef BUF_ERR_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.clear) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (is_write && full) overflow_q  <= 1'b1;
      if (is_read && empty) underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule
